// File: rtl/gcd_pkg.sv
// Shared types and mux-select encodings for the subtractive GCD controller and datapath.
package gcd_pkg;

   localparam int unsigned OP_W = 16;

   localparam logic SEL_DATA = 1'b1;
   localparam logic SEL_SUB  = 1'b0;
   localparam logic SEL_A    = 1'b1;
   localparam logic SEL_B    = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      CALC   = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/gcd_ctrl.sv
// Controller for the subtractive GCD datapath: loads A then B over a valid/ready
// handshake, subtracts the smaller from the larger until eq, with a bounded iteration budget.
module gcd_ctrl
   import gcd_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_ITER = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             gt,
   input  logic             lt,
   input  logic             eq,
   output logic             sel_in,
   output logic             sel1,
   output logic             sel2,
   output logic             LdA,
   output logic             LdB,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] iter_count
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic             to_q, to_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         iter_q  <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      iter_d   = iter_q;
      to_d     = to_q;
      in_ready = 1'b0;
      sel_in   = SEL_SUB;
      sel1     = SEL_B;
      sel2     = SEL_B;
      LdA      = 1'b0;
      LdB      = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_A;
               iter_d  = '0;
               to_d    = 1'b0;
            end
         end
         LOAD_A: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            sel_in   = SEL_DATA;
            LdA      = in_valid;
            if (in_valid) state_d = LOAD_B;
         end
         LOAD_B: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            sel_in   = SEL_DATA;
            LdB      = in_valid;
            if (in_valid) state_d = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (eq) begin
               state_d = DONE;
               to_d    = 1'b0;
            end else if (iter_q == MAX_CNT) begin
               state_d = DONE;
               to_d    = 1'b1;
            end else if (gt) begin
               sel1   = SEL_A;
               sel2   = SEL_B;
               LdA    = 1'b1;
               iter_d = iter_q + 1'b1;
            end else if (lt || !gt) begin
               // an inconsistent flag pair (none set) takes the B - A path
               sel1   = SEL_B;
               sel2   = SEL_A;
               LdB    = 1'b1;
               iter_d = iter_q + 1'b1;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign timeout    = to_q;
   assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: behavioural datapath around two instances (default budget and
// MAX_ITER=8), per-cycle expected control outputs derived from plain GCD arithmetic.
module tb_gcd_ctrl;

   localparam logic [7:0] V_IR  = 8'h80;
   localparam logic [7:0] V_SI  = 8'h40;
   localparam logic [7:0] V_S1  = 8'h20;
   localparam logic [7:0] V_S2  = 8'h10;
   localparam logic [7:0] V_LA  = 8'h08;
   localparam logic [7:0] V_LB  = 8'h04;
   localparam logic [7:0] V_BSY = 8'h02;
   localparam logic [7:0] V_DN  = 8'h01;
   localparam logic [7:0] V_LW  = V_IR | V_SI | V_BSY;

   logic clk = 1'b0;
   logic rst;
   logic start [2];
   logic in_valid [2];
   logic [15:0] data_in [2];
   logic ir_w [2], si_w [2], s1_w [2], s2_w [2], la_w [2], lb_w [2];
   logic bsy_w [2], dn_w [2], to_w [2], gt_w [2], lt_w [2], eq_w [2];
   logic [15:0] it_w [2];
   logic [15:0] ra [2];
   logic [15:0] rb [2];

   int errors = 0;
   int checks = 0;
   int ds = 0;
   logic chk_en = 1'b0;
   logic exp_cnt = 1'b0;
   logic [7:0] exp_vec = '0;
   logic [15:0] exp_iter = '0;
   logic exp_to = 1'b0;
   logic [15:0] exp_a = '0;

   always #5 clk = ~clk;

   initial begin
      ra[0] = '0; rb[0] = '0; ra[1] = '0; rb[1] = '0;
   end

   gcd_ctrl #(.CNT_W(16), .MAX_ITER(65535)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_ready(ir_w[0]),
      .gt(gt_w[0]), .lt(lt_w[0]), .eq(eq_w[0]), .sel_in(si_w[0]), .sel1(s1_w[0]), .sel2(s2_w[0]),
      .LdA(la_w[0]), .LdB(lb_w[0]), .busy(bsy_w[0]), .done(dn_w[0]), .timeout(to_w[0]),
      .iter_count(it_w[0])
   );

   gcd_ctrl #(.CNT_W(16), .MAX_ITER(8)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_ready(ir_w[1]),
      .gt(gt_w[1]), .lt(lt_w[1]), .eq(eq_w[1]), .sel_in(si_w[1]), .sel1(s1_w[1]), .sel2(s2_w[1]),
      .LdA(la_w[1]), .LdB(lb_w[1]), .busy(bsy_w[1]), .done(dn_w[1]), .timeout(to_w[1]),
      .iter_count(it_w[1])
   );

   assign gt_w[0] = ra[0] > rb[0];
   assign lt_w[0] = ra[0] < rb[0];
   assign eq_w[0] = ra[0] == rb[0];
   assign gt_w[1] = ra[1] > rb[1];
   assign lt_w[1] = ra[1] < rb[1];
   assign eq_w[1] = ra[1] == rb[1];

   // Datapath: bus mux, minuend/subtrahend muxes, subtractor, A/B registers.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [15:0] bus;
         bus = si_w[i] ? data_in[i]
                       : ((s1_w[i] ? ra[i] : rb[i]) - (s2_w[i] ? ra[i] : rb[i]));
         if (la_w[i]) ra[i] <= bus;
         if (lb_w[i]) rb[i] <= bus;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [7:0] act;
         act = {ir_w[ds], si_w[ds], s1_w[ds], s2_w[ds], la_w[ds], lb_w[ds], bsy_w[ds], dn_w[ds]};
         check("ctrl_outputs", {24'd0, act}, {24'd0, exp_vec});
         check("ld_exclusive", {31'd0, la_w[ds] & lb_w[ds]}, 32'd0);
         if (exp_cnt) begin
            check("iter_count", {16'd0, it_w[ds]}, {16'd0, exp_iter});
            check("timeout", {31'd0, to_w[ds]}, {31'd0, exp_to});
         end
         if (exp_vec[0]) check("result_A", {16'd0, ra[ds]}, {16'd0, exp_a});
      end
   end

   task automatic cyc(input logic [7:0] v);
      exp_vec = v;
      @(posedge clk);
      #1;
   endtask

   // One run on instance d. Expected outputs come from plain subtractive GCD steps.
   task automatic run(input int d, input logic [15:0] a, input logic [15:0] b,
                      input int ga, input int gb, input int maxit, input int st_busy,
                      input int rst_at, output int n, output logic [15:0] am, output logic to);
      logic [15:0] ma, mb;
      logic [7:0] v;
      ds = d; chk_en = 1'b1; exp_cnt = 1'b0;
      start[d] = 1'b1; cyc(8'h00); start[d] = 1'b0;
      for (int g = 0; g < ga; g++) begin
         in_valid[d] = 1'b0; data_in[d] = 16'($urandom); cyc(V_LW);
      end
      in_valid[d] = 1'b1; data_in[d] = a; cyc(V_LW | V_LA);
      for (int g = 0; g < gb; g++) begin
         in_valid[d] = 1'b0; data_in[d] = 16'($urandom); cyc(V_LW);
      end
      in_valid[d] = 1'b1; data_in[d] = b; cyc(V_LW | V_LB);
      in_valid[d] = 1'b0;
      ma = a; mb = b; n = 0; to = 1'b0; v = V_BSY;
      while (1) begin
         if (ma == mb) begin v = V_BSY; break; end
         if (n == maxit) begin v = V_BSY; to = 1'b1; break; end
         if (ma > mb) begin v = V_BSY | V_S1 | V_LA; ma = ma - mb; end
         else begin v = V_BSY | V_S2 | V_LB; mb = mb - ma; end
         if (n == rst_at) begin
            rst = 1'b1; cyc(v); rst = 1'b0;
            exp_cnt = 1'b1; exp_iter = '0; exp_to = 1'b0;
            cyc(8'h00); cyc(8'h00);
            exp_cnt = 1'b0;
            n = -1; am = ma;
            return;
         end
         if (n == st_busy) start[d] = 1'b1;
         cyc(v);
         start[d] = 1'b0;
         n++;
      end
      cyc(v);
      exp_cnt = 1'b1; exp_iter = 16'(n); exp_to = to; exp_a = ma;
      if (st_busy >= 0) start[d] = 1'b1;
      cyc(V_BSY | V_DN);
      start[d] = 1'b0;
      cyc(8'h00);
      exp_cnt = 1'b0;
      am = ma;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] am;
      logic to;
      start[0] = 0; start[1] = 0; in_valid[0] = 0; in_valid[1] = 0;
      data_in[0] = '0; data_in[1] = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_cnt = 1'b1; exp_iter = '0; exp_to = 1'b0; chk_en = 1'b1;
      ds = 0; cyc(8'h00);
      ds = 1; cyc(8'h00);
      exp_cnt = 1'b0;

      run(0, 16'd48, 16'd18, 0, 0, 65535, -1, -1, n, am, to);
      check("model_48_18_n", n, 4); check("model_48_18_A", {16'd0, am}, 6);
      check("model_48_18_to", {31'd0, to}, 0);

      run(0, 16'd7, 16'd7, 0, 0, 65535, -1, -1, n, am, to);
      check("model_7_7_n", n, 0); check("model_7_7_A", {16'd0, am}, 7);

      run(1, 16'd0, 16'd5, 0, 0, 8, -1, -1, n, am, to);
      check("model_0_5_n", n, 8); check("model_0_5_to", {31'd0, to}, 1);

      run(0, 16'd12, 16'd9, 0, 3, 65535, -1, -1, n, am, to);
      check("model_12_9_n", n, 3); check("model_12_9_A", {16'd0, am}, 3);

      run(0, 16'd48, 16'd18, 0, 0, 65535, -1, 2, n, am, to);
      run(0, 16'd48, 16'd18, 0, 0, 65535, 2, -1, n, am, to);
      check("model_rerun_n", n, 4); check("model_rerun_A", {16'd0, am}, 6);

      for (int r = 0; r < 25; r++) begin
         int d;
         logic [15:0] a, b;
         d = $urandom_range(0, 1);
         a = d ? 16'($urandom_range(0, 20)) : 16'($urandom_range(1, 200));
         b = d ? 16'($urandom_range(0, 20)) : 16'($urandom_range(1, 200));
         run(d, a, b, $urandom_range(0, 2), $urandom_range(0, 2), d ? 8 : 65535,
             ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : -1, -1, n, am, to);
      end

      run(1, 16'd12, 16'd0, 1, 0, 8, -1, -1, n, am, to);
      check("model_12_0_to", {31'd0, to}, 1);

      run(0, 16'd1, 16'd65535, 0, 0, 65535, -1, -1, n, am, to);
      check("model_1_65535_n", n, 65534); check("model_1_65535_A", {16'd0, am}, 1);
      check("model_1_65535_to", {31'd0, to}, 0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
